// File: rtl/ram_master.sv
// Initiator for the 8-bit-address / 32-bit-data single-port RAM bus.
// Converts valid/ready requests into RAM write/read cycles and owns the shared data bus.
`timescale 1ns/1ps

module ram_master #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [7:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        wr_en_o,
  output logic        rd_en_o,
  output logic [7:0]  addr_o,
  inout  wire  [31:0] data_io
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_TURN
  } state_e;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        oe_q, oe_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        accept;

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign accept      = req_valid_i & req_ready_o;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      oe_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_we_i) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
            cnt_d   = RD_LAT_C;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_TURN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus controls are registered, so they are decoded from the next state.
  always_comb begin
    wr_en_d     = (state_d == ST_WRITE);
    rd_en_d     = (state_d == ST_READ);
    oe_d        = (state_d == ST_WRITE);
    addr_d      = accept ? req_addr_i  : addr_q;
    wdata_d     = accept ? req_wdata_i : wdata_q;
    rsp_valid_d = (state_q == ST_READ) && (cnt_q == 3'd0);
    rsp_rdata_d = rsp_valid_d ? data_io : rsp_rdata_q;
  end

  assign wr_en_o     = wr_en_q;
  assign rd_en_o     = rd_en_q;
  assign addr_o      = addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign data_io     = oe_q ? wdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural RAM per instance (RD_LAT=1 and RD_LAT=3).
// Read data is scoreboarded; a bus monitor checks enables and data_io ownership every cycle.
`timescale 1ns/1ps

module tb_ram_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v1 = 1'b0, we1 = 1'b0;
  logic [7:0]  a1 = 8'h00;
  logic [31:0] wd1 = 32'h0;
  logic        ready1, rspv1, busy1, wr1, rd1;
  logic [7:0]  addr1;
  logic [31:0] rdata1;
  wire  [31:0] bus1;

  logic        v3 = 1'b0, we3 = 1'b0;
  logic [7:0]  a3 = 8'h00;
  logic [31:0] wd3 = 32'h0;
  logic        ready3, rspv3, busy3, wr3, rd3;
  logic [7:0]  addr3;
  logic [31:0] rdata3;
  wire  [31:0] bus3;

  ram_master #(.RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(ready1), .req_we_i(we1),
    .req_addr_i(a1), .req_wdata_i(wd1), .rsp_valid_o(rspv1), .rsp_rdata_o(rdata1),
    .busy_o(busy1), .wr_en_o(wr1), .rd_en_o(rd1), .addr_o(addr1), .data_io(bus1)
  );

  ram_master #(.RD_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_ready_o(ready3), .req_we_i(we3),
    .req_addr_i(a3), .req_wdata_i(wd3), .rsp_valid_o(rspv3), .rsp_rdata_o(rdata3),
    .busy_o(busy3), .wr_en_o(wr3), .rd_en_o(rd3), .addr_o(addr3), .data_io(bus3)
  );

  // An undriven bus reads as all ones, so any stray master drive is visible.
  pullup pu1 (bus1);
  pullup pu3 (bus3);

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  int rcnt1 = 0, rcnt3 = 0;

  assign bus1 = (rd1 === 1'b1 && rcnt1 >= 1) ? mem1[addr1] : 32'hzzzz_zzzz;
  assign bus3 = (rd3 === 1'b1 && rcnt3 >= 3) ? mem3[addr3] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (wr1 === 1'b1) mem1[addr1] <= bus1;
    if (wr3 === 1'b1) mem3[addr3] <= bus3;
    rcnt1 <= (rd1 === 1'b1) ? rcnt1 + 1 : 0;
    rcnt3 <= (rd3 === 1'b1) ? rcnt3 + 1 : 0;
  end

  int checks = 0;
  int errors = 0;
  int rsp_cnt1 = 0, rsp_cnt3 = 0, wr_cnt1 = 0, viol = 0;
  logic [31:0] q1 [$];
  logic [31:0] q3 [$];
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit bus_bad(input logic wr, input logic rd, input int rcnt, input int lat,
                                 input logic [31:0] bus, input logic [31:0] ram_word);
    logic [31:0] exp;
    if (wr === 1'b1) return (rd === 1'b1);
    exp = (rd === 1'b1 && rcnt >= lat) ? ram_word : 32'hFFFF_FFFF;
    return (bus !== exp);
  endfunction

  // Response scoreboard and per-cycle bus-ownership monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rspv1 === 1'b1) begin
        rsp_cnt1 <= rsp_cnt1 + 1;
        if (q1.size() == 0) check("rsp1_unexpected", 32'(rspv1), 32'h0);
        else                check("rsp1_data", rdata1, q1.pop_front());
      end
      if (rspv3 === 1'b1) begin
        rsp_cnt3 <= rsp_cnt3 + 1;
        if (q3.size() == 0) check("rsp3_unexpected", 32'(rspv3), 32'h0);
        else                check("rsp3_data", rdata3, q3.pop_front());
      end
      if (wr1 === 1'b1) wr_cnt1 <= wr_cnt1 + 1;
      viol <= viol + int'(bus_bad(wr1, rd1, rcnt1, 1, bus1, mem1[addr1]))
                   + int'(bus_bad(wr3, rd3, rcnt3, 3, bus3, mem3[addr3]));
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input int sel, input logic we, input logic [7:0] a, input logic [31:0] d,
                       input bit keep);
    bit found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if ((sel == 1 ? ready1 : ready3) === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check("ready_timeout", 32'(sel == 1 ? ready1 : ready3), 32'h1);
    if (sel == 1) begin v1 = 1'b1; we1 = we; a1 = a; wd1 = d; end
    else          begin v3 = 1'b1; we3 = we; a3 = a; wd3 = d; end
    @(negedge clk);
    if (!keep) begin
      if (sel == 1) v1 = 1'b0;
      else          v3 = 1'b0;
    end
  endtask

  // Samples from the first negedge after accept until the master is idle again.
  task automatic measure(input int sel, output int rd_n, output int busy_n, output int rsp_n,
                         output int rsp_at, output logic [31:0] rsp_data);
    logic r, b, s;
    logic [31:0] dd;
    rd_n = 0; busy_n = 0; rsp_n = 0; rsp_at = 0; rsp_data = 32'hx;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      r  = (sel == 1) ? rd1    : rd3;
      b  = (sel == 1) ? busy1  : busy3;
      s  = (sel == 1) ? rspv1  : rspv3;
      dd = (sel == 1) ? rdata1 : rdata3;
      if (r === 1'b1) rd_n++;
      if (b === 1'b1) busy_n++;
      if (s === 1'b1) begin
        rsp_n++;
        if (rsp_at == 0) begin rsp_at = k; rsp_data = dd; end
      end
      if (b !== 1'b1) break;
    end
  endtask

  int rd_n, busy_n, rsp_n, rsp_at, snap;
  logic [31:0] rsp_data;

  initial begin
    mem3[8'h40] = 32'h0BAD_F00D;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    check("rst_ready",     32'(ready1), 32'h1);
    check("rst_busy",      32'(busy1),  32'h0);
    check("rst_wr_en",     32'(wr1),    32'h0);
    check("rst_rd_en",     32'(rd1),    32'h0);
    check("rst_addr",      32'(addr1),  32'h0);
    check("rst_rsp_valid", 32'(rspv1),  32'h0);
    check("rst_rsp_rdata", rdata1,      32'h0);
    check("rst_bus_free",  bus1,        32'hFFFF_FFFF);

    // Single write.
    snap = rsp_cnt1;
    issue(1, 1'b1, 8'h12, 32'hDEAD_BEEF, 1'b0);
    check("wr_en_high",  32'(wr1),    32'h1);
    check("wr_rd_low",   32'(rd1),    32'h0);
    check("wr_addr",     32'(addr1),  32'h12);
    check("wr_bus_data", bus1,        32'hDEAD_BEEF);
    check("wr_ready",    32'(ready1), 32'h0);
    check("wr_busy",     32'(busy1),  32'h1);
    @(negedge clk);
    check("wr_en_done",  32'(wr1),    32'h0);
    check("wr_ready_up", 32'(ready1), 32'h1);
    check("wr_bus_free", bus1,        32'hFFFF_FFFF);
    check("wr_ram_word", mem1[8'h12], 32'hDEAD_BEEF);
    check("wr_no_rsp",   32'(rsp_cnt1 - snap), 32'h0);

    // Read back, RD_LAT=1.
    q1.push_back(32'hDEAD_BEEF);
    issue(1, 1'b0, 8'h12, 32'h0, 1'b0);
    measure(1, rd_n, busy_n, rsp_n, rsp_at, rsp_data);
    check("rd1_en_cycles",   32'(rd_n),   32'd2);
    check("rd1_busy_cycles", 32'(busy_n), 32'd3);
    check("rd1_rsp_pulses",  32'(rsp_n),  32'd1);
    check("rd1_rsp_at",      32'(rsp_at), 32'd3);
    check("rd1_rsp_data",    rsp_data,    32'hDEAD_BEEF);
    @(negedge clk);
    check("rd1_rdata_hold",  rdata1,      32'hDEAD_BEEF);

    // Mixed traffic with valid held high throughout.
    snap = wr_cnt1;
    issue(1, 1'b1, 8'h00, 32'h0000_0001, 1'b1);
    q1.push_back(32'h0000_0001);
    issue(1, 1'b0, 8'h00, 32'h0, 1'b1);
    issue(1, 1'b1, 8'hFF, 32'hA5A5_A5A5, 1'b1);
    q1.push_back(32'hA5A5_A5A5);
    issue(1, 1'b0, 8'hFF, 32'h0, 1'b0);
    measure(1, rd_n, busy_n, rsp_n, rsp_at, rsp_data);
    check("mix_last_rsp", rsp_data, 32'hA5A5_A5A5);
    @(negedge clk);
    check("mix_q_empty",   32'(q1.size()),       32'h0);
    check("mix_wr_count",  32'(wr_cnt1 - snap),  32'd2);
    check("mix_ram_00",    mem1[8'h00],          32'h0000_0001);
    check("mix_ram_ff",    mem1[8'hFF],          32'hA5A5_A5A5);
    check("mix_addr_hold", 32'(addr1),           32'hFF);

    // Read with RD_LAT=3.
    q3.push_back(32'h0BAD_F00D);
    issue(3, 1'b0, 8'h40, 32'h0, 1'b0);
    measure(3, rd_n, busy_n, rsp_n, rsp_at, rsp_data);
    check("rd3_en_cycles",   32'(rd_n),   32'd4);
    check("rd3_busy_cycles", 32'(busy_n), 32'd5);
    check("rd3_rsp_at",      32'(rsp_at), 32'd5);
    check("rd3_rsp_data",    rsp_data,    32'h0BAD_F00D);

    // Reset asserted mid-cycle during the second read-enable cycle.
    issue(1, 1'b0, 8'h12, 32'h0, 1'b0);
    check("rr_rd_first", 32'(rd1), 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rr_rd_en",     32'(rd1),    32'h0);
    check("rr_busy",      32'(busy1),  32'h0);
    check("rr_ready",     32'(ready1), 32'h1);
    check("rr_addr",      32'(addr1),  32'h0);
    check("rr_rsp_valid", 32'(rspv1),  32'h0);
    check("rr_rsp_rdata", rdata1,      32'h0);
    check("rr_bus_free",  bus1,        32'hFFFF_FFFF);
    snap = rsp_cnt1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rr_no_rsp", 32'(rsp_cnt1 - snap), 32'h0);
    q1.push_back(32'hDEAD_BEEF);
    issue(1, 1'b0, 8'h12, 32'h0, 1'b0);
    measure(1, rd_n, busy_n, rsp_n, rsp_at, rsp_data);
    check("rr_after_rsp_at",   32'(rsp_at), 32'd3);
    check("rr_after_rsp_data", rsp_data,    32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    check("bus_violations", 32'(viol),       32'h0);
    check("q1_drained",     32'(q1.size()),  32'h0);
    check("q3_drained",     32'(q3.size()),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
